// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the single-ported emulation RAM
// between the fetch port (if_*) and the load/store port (d_*).
// Ports:
//   clk, rstn           clock, async active-low reset
//   if_req/if_addr      fetch request (word access), if_gnt accept
//   if_rvalid/rdata/err fetch response, one cycle after grant
//   d_req/we/rwtyp/addr/wdata  data request (funct3 size), d_gnt accept
//   d_rvalid/rdata/err  data response, loads sign-extended, stores rdata=0
//   ram_*               RAM control, driven only on a legal grant
//   ram_q               RAM read data, valid one cycle after ram_rden
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_rwtyp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic [2:0]            ram_rwtyp,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    output logic                  ram_rden,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef struct packed {
        logic       valid;
        owner_t     owner;
        logic       is_store;
        logic [2:0] rwtyp;
        logic       err;
    } rsp_t;

    owner_t last_owner;
    rsp_t   rsp_q;
    rsp_t   rsp_d;
    logic   gnt_if;
    logic   gnt_d;
    logic   if_bad;
    logic   d_bad;

    // Grants are held off while reset is asserted so every output is 0.
    // On a tie the port that did not win last time goes first.
    always_comb begin
        gnt_if = rstn && if_req && (!d_req || last_owner == OWN_D);
        gnt_d  = rstn && d_req && !gnt_if;
    end

    assign if_gnt = gnt_if;
    assign d_gnt  = gnt_d;
    assign if_bad = |if_addr[1:0];

    always_comb begin
        d_bad = 1'b1;
        unique case (d_rwtyp)
            3'b000, 3'b100: d_bad = 1'b0;
            3'b001, 3'b101: d_bad = d_addr[0];
            3'b010:         d_bad = |d_addr[1:0];
            default:        d_bad = 1'b1;
        endcase
    end

    // Illegal grants leave the RAM idle; the request is still consumed.
    always_comb begin
        ram_rwtyp = 3'b000;
        ram_addr  = '0;
        ram_data  = '0;
        ram_wren  = 1'b0;
        ram_rden  = 1'b0;
        if (gnt_if && !if_bad) begin
            ram_rwtyp = 3'b010;
            ram_addr  = if_addr;
            ram_rden  = 1'b1;
        end else if (gnt_d && !d_bad) begin
            ram_rwtyp = d_rwtyp;
            ram_addr  = d_addr;
            ram_data  = d_wdata;
            ram_wren  = d_we;
            ram_rden  = !d_we;
        end
    end

    always_comb begin
        rsp_d          = '0;
        rsp_d.valid    = gnt_if || gnt_d;
        rsp_d.owner    = gnt_d ? OWN_D : OWN_IF;
        rsp_d.is_store = gnt_d && d_we;
        rsp_d.rwtyp    = gnt_d ? d_rwtyp : 3'b010;
        rsp_d.err      = gnt_if ? if_bad : (gnt_d && d_bad);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_q      <= '0;
            last_owner <= OWN_D;
        end else begin
            rsp_q <= rsp_d;
            if (gnt_if) begin
                last_owner <= OWN_IF;
            end else if (gnt_d) begin
                last_owner <= OWN_D;
            end
        end
    end

    // The RAM returns sub-words zero-extended; only signed B/H need fixing.
    logic [DATA_WIDTH-1:0] ext_q;

    always_comb begin
        ext_q = ram_q;
        unique case (rsp_q.rwtyp)
            3'b000:  ext_q = {{(DATA_WIDTH-8){ram_q[7]}}, ram_q[7:0]};
            3'b001:  ext_q = {{(DATA_WIDTH-16){ram_q[15]}}, ram_q[15:0]};
            default: ext_q = ram_q;
        endcase
    end

    always_comb begin
        if_rvalid = rsp_q.valid && rsp_q.owner == OWN_IF;
        d_rvalid  = rsp_q.valid && rsp_q.owner == OWN_D;
        if_err    = if_rvalid && rsp_q.err;
        d_err     = d_rvalid && rsp_q.err;
        if_rdata  = (if_rvalid && !rsp_q.err) ? ram_q : '0;
        d_rdata   = (d_rvalid && !rsp_q.err && !rsp_q.is_store) ? ext_q : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, legality,
// load extension and reset behaviour against a small byte RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_rwtyp = 3'b010;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [2:0]  ram_rwtyp;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic        ram_rden;
    logic [31:0] ram_q;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_rwtyp(d_rwtyp),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_rwtyp(ram_rwtyp), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_rden(ram_rden), .ram_q(ram_q)
    );

    // Byte RAM model: sub-word reads come back zero-extended.
    logic [7:0] mem [0:1023];

    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr[9:0]] <= ram_data[7:0];
            if (ram_rwtyp[1:0] != 2'b00)
                mem[ram_addr[9:0] + 10'd1] <= ram_data[15:8];
            if (ram_rwtyp[1:0] == 2'b10) begin
                mem[ram_addr[9:0] + 10'd2] <= ram_data[23:16];
                mem[ram_addr[9:0] + 10'd3] <= ram_data[31:24];
            end
        end
        if (ram_rden) begin
            case (ram_rwtyp[1:0])
                2'b00: ram_q <= {24'h0, mem[ram_addr[9:0]]};
                2'b01: ram_q <= {16'h0, mem[ram_addr[9:0] + 10'd1],
                                 mem[ram_addr[9:0]]};
                default: ram_q <= {mem[ram_addr[9:0] + 10'd3],
                                   mem[ram_addr[9:0] + 10'd2],
                                   mem[ram_addr[9:0] + 10'd1],
                                   mem[ram_addr[9:0]]};
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; one grant cycle, one response cycle.
    task automatic do_d(input string tag, input logic we,
                        input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] erd,
                        input logic eerr);
        d_req = 1'b1; d_we = we; d_rwtyp = t; d_addr = a; d_wdata = w;
        #1;
        chk({tag, ".gnt"}, {31'b0, d_gnt}, 32'd1);
        chk({tag, ".en"}, {30'b0, ram_rden, ram_wren},
            eerr ? 32'd0 : (we ? 32'd1 : 32'd2));
        if (!eerr) chk({tag, ".addr"}, ram_addr, a);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk({tag, ".rvalid"}, {30'b0, d_rvalid, if_rvalid}, 32'd2);
        chk({tag, ".err"}, {31'b0, d_err}, {31'b0, eerr});
        chk({tag, ".rdata"}, d_rdata, erd);
    endtask

    task automatic do_if(input string tag, input logic [31:0] a,
                         input logic [31:0] erd, input logic eerr);
        if_req = 1'b1; if_addr = a;
        #1;
        chk({tag, ".gnt"}, {31'b0, if_gnt}, 32'd1);
        chk({tag, ".en"}, {30'b0, ram_rden, ram_wren},
            eerr ? 32'd0 : 32'd2);
        if (!eerr) chk({tag, ".addr"}, ram_addr, a);
        @(posedge clk); #1;
        if_req = 1'b0;
        chk({tag, ".rvalid"}, {30'b0, d_rvalid, if_rvalid}, 32'd1);
        chk({tag, ".err"}, {31'b0, if_err}, {31'b0, eerr});
        chk({tag, ".rdata"}, if_rdata, erd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int hits;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        chk("rst.rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        chk("rst.en", {30'b0, ram_rden, ram_wren}, 32'd0);
        chk("rst.rdata", if_rdata | d_rdata, 32'd0);
        chk("rst.addr", ram_addr, 32'd0);
        rstn = 1'b1;

        // Contention: IF, D, IF, D with responses one cycle behind.
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_rwtyp = 3'b010; d_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr.gnt", {30'b0, if_gnt, d_gnt},
                (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i > 0)
                chk("rr.rvalid", {30'b0, if_rvalid, d_rvalid},
                    (i % 2 == 1) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("rr.last", {30'b0, if_rvalid, d_rvalid}, 32'd1);

        // Tie with an illegal fetch winner: D goes next cycle.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h101; d_req = 1'b1;
        #1;
        chk("tie_bad.gnt", {30'b0, if_gnt, d_gnt}, 32'd2);
        chk("tie_bad.en", {30'b0, ram_rden, ram_wren}, 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
        #1;
        chk("tie_bad.gnt2", {30'b0, if_gnt, d_gnt}, 32'd1);
        chk("tie_bad.iferr", {30'b0, if_rvalid, if_err}, 32'd3);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("tie_bad.drv", {30'b0, if_rvalid, d_rvalid}, 32'd1);

        do_d("sw100", 1'b1, 3'b010, 32'h100, 32'h13, 32'h0, 1'b0);
        do_if("fetch", 32'h100, 32'h13, 1'b0);
        do_d("sb", 1'b1, 3'b000, 32'h203, 32'h80, 32'h0, 1'b0);
        do_d("lb", 1'b0, 3'b000, 32'h203, 32'h0, 32'hFFFF_FF80, 1'b0);
        do_d("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80, 1'b0);
        do_d("sh", 1'b1, 3'b001, 32'h202, 32'h8001, 32'h0, 1'b0);
        do_d("lh", 1'b0, 3'b001, 32'h202, 32'h0, 32'hFFFF_8001, 1'b0);
        do_d("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 32'h8001, 1'b0);
        do_d("lw_mis", 1'b0, 3'b010, 32'h302, 32'h0, 32'h0, 1'b1);
        do_if("if_mis", 32'h101, 32'h0, 1'b1);
        do_d("sw304", 1'b1, 3'b010, 32'h304, 32'h0, 32'h0, 1'b0);
        do_d("sh_mis", 1'b1, 3'b001, 32'h305, 32'hABCD, 32'h0, 1'b1);
        do_d("lw304", 1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 1'b0);
        do_d("rwt011", 1'b0, 3'b011, 32'h300, 32'h0, 32'h0, 1'b1);
        do_d("rwt110", 1'b1, 3'b110, 32'h300, 32'h5, 32'h0, 1'b1);

        // Reset between grant and response drops the response.
        d_req = 1'b1; d_we = 1'b0; d_rwtyp = 3'b010; d_addr = 32'h100;
        #1;
        chk("mid.gnt", {31'b0, d_gnt}, 32'd1);
        #2;
        d_req = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid.rst.gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        chk("mid.rst.rv", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        chk("mid.rst.en", {30'b0, ram_rden, ram_wren}, 32'd0);
        @(posedge clk); #1;
        chk("mid.rst.rv2", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        hits = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (if_rvalid || d_rvalid) hits++;
        end
        chk("mid.no_rvalid", hits, 32'd0);

        // First tie after reset goes to fetch.
        if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1;
        #1;
        chk("post.tie", {30'b0, if_gnt, d_gnt}, 32'd2);
        @(posedge clk); #1;
        if_req = 1'b0;
        chk("post.ifrd", if_rdata, 32'h13);
        #1;
        chk("post.dgnt", {30'b0, if_gnt, d_gnt}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("post.drd", d_rdata, 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port front end for the single-ported emulation RAM. It shares the RAM between the instruction-fetch port and the load/store port using round-robin arbitration. It also rejects misaligned or illegal accesses before they reach the RAM, and sign-extends signed sub-word loads, because the RAM returns them zero-extended. It sits between the core's fetch/LSU stages and the RAM instance; it is the only driver of the RAM's control inputs.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width; only 32 is supported
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_WIDTH  fetch byte address; always a word access
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch instruction word
- if_err  out  1  fetch misaligned; qualifies if_rvalid
- d_req  in  1  data request; held with its payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_rwtyp  in  3  RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  32  store data, LSB-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid; loads and stores both get one
- d_rdata  out  32  load result after extension; 0 for stores
- d_err  out  1  misaligned or illegal rwtyp; qualifies d_rvalid
- ram_rwtyp  out  3  RAM access type
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_data  out  32  RAM write data
- ram_wren  out  1  RAM write enable
- ram_rden  out  1  RAM read enable
- ram_q  in  32  RAM read data, valid one cycle after ram_rden

## Operation
- **Arbitration** (combinational, each cycle):
  - If only one port requests, that port wins.
  - If both request, the port not granted most recently wins.
  - The last_owner register updates on every grant. It resets to DATA, so fetch wins the first tie.
  - At most one gnt per cycle; gnt is never asserted without the matching req.
- **Legality check** on the granted request:
  - Fetch is illegal if addr[1:0]≠0.
  - Data is illegal if rwtyp ∈ {011,110,111}; if H/HU with addr[0]=1; or if W with addr[1:0]≠0.
- **Legal grant:**
  - Drive ram_addr, ram_rwtyp (fetch uses 010), and ram_data=d_wdata.
  - Set ram_rden=!we (fetch always reads) or ram_wren=we.
- **Illegal grant:** ram_rden=ram_wren=0. The RAM is untouched; the request is still consumed.
- **Response register**, written on any grant:
  - Holds {valid, owner, is_store, rwtyp, err}.
  - Next cycle it produces exactly one rvalid on the owner's port.
- **Load extension:**
  - 000: sign-extend from ram_q[7].
  - 001: sign-extend from ram_q[15].
  - 100, 101, 010: ram_q unchanged.
- **Store and error responses:** rdata=0. Store with no error: rvalid=1, err=0.
- When no grant occurs, all ram_* outputs are 0.

## Timing
- Grant cycle T:
  - gnt and the ram_* signals are combinational from req.
  - rvalid, rdata and err appear in T+1 and last exactly one cycle.
- Fully pipelined: a new grant is allowed every cycle, including back-to-back grants to the same port. The throughput is one access per cycle.
- rdata is combinational from ram_q plus the response register; there is no extra register stage.
- Reset values: if_gnt=d_gnt=0, if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, if_err=d_err=0, all ram_*=0, response valid=0, last_owner=DATA.
- Reset asserted mid-transaction: the pending response is discarded, and no rvalid appears after rstn rises. A write already sampled by the RAM stays committed.
- Simultaneous requests with an illegal winner: the loser waits and is granted the next cycle, so round-robin order is preserved.
- Requester drops req without gnt: legal; nothing is issued.

## Test plan
- **Solo fetch:** preload word 0x0000_0013 at 0x100, if_req with addr 0x100 -> if_gnt in T, ram_rden=1 with ram_addr=0x100, if_rvalid=1 with if_rdata=0x0000_0013 in T+1.
- **Signed and unsigned loads:** store SB 0x80 at 0x203, then load LB and LBU at 0x203 -> d_rdata=0xFFFF_FF80 for LB and 0x0000_0080 for LBU. Store SH 0x8001 at 0x202 and load LH -> 0xFFFF_8001.
- **Contention:** if_req and d_req held high for 4 cycles after reset -> grants alternate IF, D, IF, D. Each rvalid follows its grant by one cycle on the correct port.
- **Misaligned access:**
  - LW at 0x302 -> d_gnt, ram_rden=ram_wren=0, d_rvalid=1 with d_err=1 and d_rdata=0.
  - Fetch at 0x101 -> if_err=1.
  - SH at 0x305 -> d_err=1 and memory unchanged.
- **Illegal rwtyp:** d_rwtyp=011 -> d_err=1, no RAM enable asserted.
- **Reset mid-flight:** grant an LW at T, pulse rstn low between T and T+1 -> no d_rvalid at any point after release, all outputs 0 during reset, and the first tie after reset goes to fetch.
